mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter LAT, default 2, memory access latency in cycles; legal range 1..15.
REQ-004 Parameter STARVE, default 4, consecutive MEM grants with IF pending before IF is forced; legal range 1..15.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 if_req  in  1  fetch-stage request; held high until if_ack.
REQ-008 if_addr  in  AW  fetch address.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 if_rdata  out  DW  fetched word; valid when if_ack is high.
REQ-011 mem_req  in  1  data-stage request; held high until mem_ack.
REQ-012 mem_we  in  1  data-stage write enable (1 = write).
REQ-013 mem_addr  in  AW  data address.
REQ-014 mem_wdata  in  DW  store data.
REQ-015 mem_ack  out  1  one-cycle data completion pulse.
REQ-016 mem_rdata  out  DW  load data; valid when mem_ack is high with a read.
REQ-017 if_stall  out  1  combinational: if_req & ~if_ack.
REQ-018 mem_stall  out  1  combinational: mem_req & ~mem_ack.
REQ-019 m_en, m_we  out  1 each  single-port memory enable and write enable.
REQ-020 m_addr  out  AW; m_wdata  out  DW; m_rdata  in  DW; m_rdata is valid on the last m_en cycle.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-022 In IDLE, when any request is sampled at an edge, the arbiter SHALL latch the winner's address, write data and we, select the owner, set the counter to LAT-1, and enter BUSY.
REQ-023 Priority SHALL go to MEM over IF, unless the starve counter equals STARVE and both request, in which case IF SHALL win.
REQ-024 The starve counter SHALL increment on each MEM grant while if_req is high, saturate at STARVE, and clear on any IF grant.
REQ-025 In BUSY, m_en SHALL be high and m_addr, m_wdata and m_we SHALL hold the latched values; m_we SHALL be 0 for IF grants.
REQ-026 In BUSY with counter 0, the arbiter SHALL register m_rdata into the owner's rdata register on reads and enter DONE; otherwise it SHALL decrement the counter.
REQ-027 On writes, mem_rdata SHALL keep its prior value.
REQ-028 In DONE, the owner's ack SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE; m_en SHALL be low.
REQ-029 Requests SHALL be ignored in BUSY and DONE; a request still high in the DONE cycle SHALL NOT cause a grant until sampled in IDLE.
REQ-030 Latency SHALL be fixed: request sampled at edge k -> m_en high for cycles k+1..k+LAT -> ack high in cycle k+LAT+1.
REQ-031 Back-to-back throughput SHALL be one access per LAT+2 cycles.
REQ-032 if_rdata and mem_rdata SHALL hold their values between acks.
REQ-033 Input changes during BUSY SHALL NOT affect the memory outputs.

Reset
REQ-034 When rst is low, the following SHALL apply immediately and asynchronously: state IDLE; counter 0; starve counter 0; m_en, m_we, if_ack and mem_ack 0; m_addr, m_wdata, if_rdata and mem_rdata 0.
REQ-035 Reset during BUSY SHALL abort the access without generating an ack; the requester SHALL reissue; partial write effects are undefined.
REQ-036 The first grant after rst rises SHALL occur at the first edge where rst is high and a request is sampled.

Verification (LAT=2, STARVE=4)
REQ-037 Single IF read, addr 0x40, m_rdata=0xDEADBEEF -> m_en high 2 cycles; if_ack 1 cycle later; if_rdata=0xDEADBEEF; if_stall high for 3 cycles.
REQ-038 Simultaneous if_req and mem_req (read 0x100) -> MEM served first, mem_ack at cycle 3; IF granted next IDLE, if_ack at cycle 7.
REQ-039 mem_req held high continuously with if_req high -> 4 MEM grants, then IF grant, then MEM resumes.
REQ-040 MEM write addr 0x200, data 0x12345678 -> m_we=1 for 2 cycles with stable m_addr/m_wdata; mem_ack pulse; mem_rdata unchanged.
REQ-041 rst low during second BUSY cycle -> m_en drops immediately, no ack; after release, reissued request completes normally.
REQ-042 Address change on if_addr mid-BUSY -> m_addr stays at the originally latched value.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch and data stage) sharing one single-port memory with fixed latency.
// MEM has priority; a starvation counter forces an IF grant after STARVE consecutive MEM wins.
module mem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned LAT    = 2,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          mem_req_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic          mem_ack_o,
  output logic [DW-1:0] mem_rdata_o,
  output logic          if_stall_o,
  output logic          mem_stall_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] CntInit   = 4'(LAT - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          owner_mem_q, owner_mem_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          grant_if;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    grant_if    = 1'b0;
    case (state_q)
      StIdle: begin
        if (if_req_i || mem_req_i) begin
          // IF only wins when MEM is absent or IF has waited out STARVE MEM grants.
          grant_if    = if_req_i && (!mem_req_i || (starve_q == StarveMax));
          state_d     = StBusy;
          cnt_d       = CntInit;
          owner_mem_d = !grant_if;
          if (grant_if) begin
            addr_d   = if_addr_i;
            wdata_d  = '0;
            we_d     = 1'b0;
            starve_d = '0;
          end else begin
            addr_d  = mem_addr_i;
            wdata_d = mem_wdata_i;
            we_d    = mem_we_i;
            if (if_req_i && (starve_q != StarveMax)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (!we_q) begin
            if (owner_mem_q) begin
              mem_rdata_d = m_rdata_i;
            end else begin
              if_rdata_d = m_rdata_i;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Strobes decode from state so an asynchronous reset drops them at once.
  always_comb begin
    m_en_o      = (state_q == StBusy);
    m_we_o      = (state_q == StBusy) && we_q;
    m_addr_o    = addr_q;
    m_wdata_o   = wdata_q;
    if_ack_o    = (state_q == StDone) && !owner_mem_q;
    mem_ack_o   = (state_q == StDone) && owner_mem_q;
    if_rdata_o  = if_rdata_q;
    mem_rdata_o = mem_rdata_q;
    if_stall_o  = if_req_i && !if_ack_o;
    mem_stall_o = mem_req_i && !mem_ack_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LAT=2, STARVE=4; memory returns ~addr unless overridden.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_ack, mem_ack, if_stall, mem_stall, m_en, m_we;
  logic [DW-1:0] if_rdata, mem_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  logic          use_fixed, hold_mem;
  logic [DW-1:0] fixed_val;

  logic          s_if_ack, s_mem_ack, s_m_en, s_m_we, s_if_stall, s_mem_stall;
  logic [AW-1:0] s_m_addr;
  logic [DW-1:0] s_m_wdata, s_if_rdata, s_mem_rdata;

  int n_chk;
  int n_fail;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .LAT(2), .STARVE(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ack_o   (if_ack),
    .if_rdata_o (if_rdata),
    .mem_req_i  (mem_req),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_ack_o  (mem_ack),
    .mem_rdata_o(mem_rdata),
    .if_stall_o (if_stall),
    .mem_stall_o(mem_stall),
    .m_en_o     (m_en),
    .m_we_o     (m_we),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_rdata_i  (m_rdata)
  );

  assign m_rdata = use_fixed ? fixed_val : ~m_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot one cycle at the falling edge, then retire acked requests just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_if_ack    = if_ack;
    s_mem_ack   = mem_ack;
    s_m_en      = m_en;
    s_m_we      = m_we;
    s_if_stall  = if_stall;
    s_mem_stall = mem_stall;
    s_m_addr    = m_addr;
    s_m_wdata   = m_wdata;
    s_if_rdata  = if_rdata;
    s_mem_rdata = mem_rdata;
    @(posedge clk);
    #1;
    if (s_if_ack) if_req = 1'b0;
    if (s_mem_ack && !hold_mem) mem_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    if_req   = 1'b0;
    mem_req  = 1'b0;
    hold_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++; if (m_en !== 1'b0 || m_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: m_en=%b m_we=%b want 0 0", m_en, m_we);
    end
    n_chk++; if (if_ack !== 1'b0 || mem_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_acks: if_ack=%b mem_ack=%b want 0 0", if_ack, mem_ack);
    end
    n_chk++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: m_addr=%h m_wdata=%h want 0 0", m_addr, m_wdata);
    end
    n_chk++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: if_rdata=%h mem_rdata=%h want 0 0", if_rdata, mem_rdata);
    end
    do_reset();
  endtask

  task automatic test_if_read();
    int stall_cnt;
    stall_cnt = 0;
    use_fixed = 1'b1;
    fixed_val = 32'hDEAD_BEEF;
    if_addr   = 32'h40;
    if_req    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (s_if_stall) stall_cnt++;
      case (c)
        0: begin
          n_chk++; if (s_m_en !== 1'b0 || s_if_stall !== 1'b1) begin
            n_fail++; $display("FAIL if_c0: m_en=%b stall=%b want 0 1", s_m_en, s_if_stall);
          end
        end
        1, 2: begin
          n_chk++; if (s_m_en !== 1'b1 || s_m_we !== 1'b0 || s_m_addr !== 32'h40) begin
            n_fail++; $display("FAIL if_busy c%0d: m_en=%b m_we=%b m_addr=%h want 1 0 40",
                               c, s_m_en, s_m_we, s_m_addr);
          end
          if (c == 1) if_addr = 32'h44;
        end
        3: begin
          n_chk++; if (s_if_ack !== 1'b1 || s_if_rdata !== 32'hDEAD_BEEF || s_m_en !== 1'b0) begin
            n_fail++; $display("FAIL if_done: ack=%b rdata=%h m_en=%b want 1 deadbeef 0",
                               s_if_ack, s_if_rdata, s_m_en);
          end
        end
        default: begin
          n_chk++; if (s_if_ack !== 1'b0 || s_if_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL if_hold: ack=%b rdata=%h want 0 deadbeef", s_if_ack, s_if_rdata);
          end
        end
      endcase
    end
    n_chk++; if (stall_cnt != 3) begin
      n_fail++; $display("FAIL if_stall_len: got %0d want 3", stall_cnt);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_priority();
    int mem_ack_c, if_ack_c;
    do_reset();
    mem_ack_c = -1;
    if_ack_c  = -1;
    if_addr   = 32'h80;
    mem_addr  = 32'h100;
    mem_we    = 1'b0;
    if_req    = 1'b1;
    mem_req   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (s_mem_ack && mem_ack_c < 0) mem_ack_c = c;
      if (s_if_ack && if_ack_c < 0) if_ack_c = c;
      if (c == 1) begin
        n_chk++; if (s_m_addr !== 32'h100) begin
          n_fail++; $display("FAIL prio_first_addr: got %h want 100", s_m_addr);
        end
      end
      if (c == 4) begin
        n_chk++; if (s_m_en !== 1'b0) begin
          n_fail++; $display("FAIL prio_idle_gap: m_en=%b want 0", s_m_en);
        end
      end
    end
    n_chk++; if (mem_ack_c != 3 || if_ack_c != 7) begin
      n_fail++; $display("FAIL prio_ack_cycles: mem=%0d if=%0d want 3 7", mem_ack_c, if_ack_c);
    end
    n_chk++; if (mem_rdata !== 32'hFFFF_FEFF || if_rdata !== 32'hFFFF_FF7F) begin
      n_fail++; $display("FAIL prio_rdata: mem=%h if=%h want fffffeff ffffff7f", mem_rdata, if_rdata);
    end
  endtask

  task automatic test_starve();
    logic [AW-1:0] exp_addr [6];
    logic [AW-1:0] g_addr [6];
    int            g_cyc [6];
    int            ngr;
    logic          prev_en;
    exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    do_reset();
    ngr      = 0;
    prev_en  = 1'b0;
    hold_mem = 1'b1;
    mem_addr = 32'h400;
    mem_we   = 1'b0;
    if_addr  = 32'h300;
    if_req   = 1'b1;
    mem_req  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (s_m_en && !prev_en && ngr < 6) begin
        g_addr[ngr] = s_m_addr;
        g_cyc[ngr]  = c;
        ngr++;
      end
      prev_en = s_m_en;
    end
    n_chk++; if (ngr != 6) begin
      n_fail++; $display("FAIL starve_grant_count: got %0d want 6", ngr);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_chk++; if (g_addr[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL starve_order g%0d: addr=%h want %h", i, g_addr[i], exp_addr[i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        n_chk++; if (g_cyc[i+1] - g_cyc[i] != 4) begin
          n_fail++; $display("FAIL b2b_spacing g%0d: got %0d want 4", i, g_cyc[i+1] - g_cyc[i]);
        end
      end
    end
    hold_mem = 1'b0;
    mem_req  = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_write();
    do_reset();
    mem_addr = 32'h80;
    mem_we   = 1'b0;
    mem_req  = 1'b1;
    repeat (5) cyc();
    n_chk++; if (mem_rdata !== 32'hFFFF_FF7F) begin
      n_fail++; $display("FAIL wr_preload: mem_rdata=%h want ffffff7f", mem_rdata);
    end
    mem_addr  = 32'h200;
    mem_wdata = 32'h1234_5678;
    mem_we    = 1'b1;
    mem_req   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      case (c)
        1, 2: begin
          n_chk++; if (s_m_en !== 1'b1 || s_m_we !== 1'b1 || s_m_addr !== 32'h200 ||
                       s_m_wdata !== 32'h1234_5678 || s_mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL wr_busy c%0d: en=%b we=%b addr=%h wdata=%h stall=%b",
                               c, s_m_en, s_m_we, s_m_addr, s_m_wdata, s_mem_stall);
          end
          if (c == 1) begin
            mem_addr  = 32'h999;
            mem_wdata = 32'h0;
          end
        end
        3: begin
          n_chk++; if (s_mem_ack !== 1'b1 || s_mem_rdata !== 32'hFFFF_FF7F ||
                       s_m_we !== 1'b0 || s_mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: ack=%b rdata=%h we=%b stall=%b want 1 ffffff7f 0 0",
                               s_mem_ack, s_mem_rdata, s_m_we, s_mem_stall);
          end
        end
        default: ;
      endcase
    end
    mem_we = 1'b0;
  endtask

  task automatic test_reset_abort();
    int   ack_c;
    logic any_ack;
    do_reset();
    ack_c   = -1;
    any_ack = 1'b0;
    if_addr = 32'h500;
    if_req  = 1'b1;
    cyc();
    cyc();
    n_chk++; if (m_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_busy2: m_en=%b want 1", m_en);
    end
    rst_n = 1'b0;
    #1;
    n_chk++; if (m_en !== 1'b0 || m_addr !== 32'h0) begin
      n_fail++; $display("FAIL abort_async: m_en=%b m_addr=%h want 0 0", m_en, m_addr);
    end
    repeat (2) begin
      cyc();
      if (s_if_ack) any_ack = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (s_if_ack && ack_c < 0) ack_c = c;
    end
    n_chk++; if (any_ack !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_ack: saw ack=%b want 0", any_ack);
    end
    n_chk++; if (ack_c != 3 || if_rdata !== 32'hFFFF_FAFF) begin
      n_fail++; $display("FAIL abort_reissue: ack cycle=%0d rdata=%h want 3 fffffaff", ack_c, if_rdata);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    use_fixed = 1'b0;
    hold_mem  = 1'b0;
    fixed_val = '0;
    if_req    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    if_addr   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    test_reset();
    test_if_read();
    test_priority();
    test_starve();
    test_write();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
